// File: rtl/mult_acc_pkg.sv
// rtl/mult_acc_pkg.sv - shared types and default widths for the product accumulator
package mult_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int P_WIDTH_DEF   = 32;
    localparam int ACC_WIDTH_DEF = 40;
    localparam int CNT_WIDTH     = 16;

endpackage

// File: rtl/mult_acc_stage_if.sv
// rtl/mult_acc_stage_if.sv - product input stream and result output stream of the accumulator
interface mult_acc_stage_if
    import mult_acc_pkg::*;
#(
    parameter int P_WIDTH   = P_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
);
    logic [P_WIDTH-1:0]   p_in;
    logic                 p_valid;
    logic                 p_ready;
    logic [ACC_WIDTH-1:0] acc_out;
    logic                 acc_valid;
    logic                 acc_ready;

    // master: the surrounding system (product source and result sink)
    modport master (
        output p_in, p_valid, acc_ready,
        input  p_ready, acc_out, acc_valid
    );

    modport slave (
        input  p_in, p_valid, acc_ready,
        output p_ready, acc_out, acc_valid
    );
endinterface

// File: rtl/mult_acc_add.sv
// rtl/mult_acc_add.sv - accumulator adder; MULT_ACC_SAT_EN selects saturating instead of wrapping
module mult_acc_add
    import mult_acc_pkg::*;
#(
    parameter int P_WIDTH   = P_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [P_WIDTH-1:0]   b,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sat
);
`ifdef MULT_ACC_SAT_EN
    logic [ACC_WIDTH:0] full;

    always_comb begin
        full = {1'b0, a} + {{(ACC_WIDTH + 1 - P_WIDTH){1'b0}}, b};
        sat  = full[ACC_WIDTH];
        sum  = full[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : full[ACC_WIDTH-1:0];
    end
`else
    always_comb begin
        sum = a + {{(ACC_WIDTH - P_WIDTH){1'b0}}, b};
        sat = 1'b0;
    end
`endif
endmodule

// File: rtl/mult_acc_stage.sv
// rtl/mult_acc_stage.sv - sums N_TERMS products and presents each total on a valid/ready output
module mult_acc_stage
    import mult_acc_pkg::*;
#(
    parameter int P_WIDTH   = P_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int N_TERMS   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    mult_acc_stage_if.slave      bus,
    output logic [CNT_WIDTH-1:0] term_cnt,
    output logic                 sat_flag
);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(N_TERMS - 1);

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_out_r;
    logic                 acc_valid_r;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_sat;
    logic                 p_ready;
    logic                 accept;

    assign p_ready       = (state == ACCUM) && !clear;
    assign accept        = bus.p_valid && p_ready;
    assign bus.p_ready   = p_ready;
    assign bus.acc_out   = acc_out_r;
    assign bus.acc_valid = acc_valid_r;

    mult_acc_add #(
        .P_WIDTH   (P_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_add (
        .a   (acc),
        .b   (bus.p_in),
        .sum (add_sum),
        .sat (add_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            acc         <= '0;
            acc_out_r   <= '0;
            acc_valid_r <= 1'b0;
            term_cnt    <= '0;
            sat_flag    <= 1'b0;
        end else if (clear) begin
            // acc_out deliberately keeps the last completed result
            state       <= ACCUM;
            acc         <= '0;
            acc_valid_r <= 1'b0;
            term_cnt    <= '0;
            sat_flag    <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (add_sat) begin
                            sat_flag <= 1'b1;
                        end
                        if (term_cnt == LAST_IDX) begin
                            acc_out_r   <= add_sum;
                            acc_valid_r <= 1'b1;
                            acc         <= '0;
                            term_cnt    <= '0;
                            state       <= HOLD;
                        end else begin
                            acc      <= add_sum;
                            term_cnt <= term_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.acc_ready) begin
                        acc_valid_r <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_acc_stage.sv
// tb/tb_mult_acc_stage.sv - five accumulator configurations on shared stimulus, checked against a sum model
module tb_mult_acc_stage;
    localparam int NI = 5;

    function automatic int nt_of(input int g);
        case (g)
            0: return 4;
            1: return 16;
            2: return 3;
            3: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int aw_of(input int g);
        return (g == 3) ? 33 : 40;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] p_in = '0;
    logic        p_valid = 1'b0;
    logic        acc_ready = 1'b1;

    logic [63:0] ao [NI];
    logic        av [NI];
    logic        pr [NI];
    logic [15:0] tc [NI];
    logic        sf [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int AW = aw_of(g);
        localparam int NT = nt_of(g);

        mult_acc_stage_if #(.P_WIDTH(32), .ACC_WIDTH(AW)) bus ();

        assign bus.p_in      = p_in;
        assign bus.p_valid   = p_valid;
        assign bus.acc_ready = acc_ready;
        assign ao[g] = 64'(bus.acc_out);
        assign av[g] = bus.acc_valid;
        assign pr[g] = bus.p_ready;

        mult_acc_stage #(.P_WIDTH(32), .ACC_WIDTH(AW), .N_TERMS(NT)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .bus      (bus),
            .term_cnt (tc[g]),
            .sat_flag (sf[g])
        );
    end

    // Model: running sum, count of terms taken, whether a result is waiting
    bit              m_hold [NI] = '{default: 1'b0};
    longint unsigned m_sum  [NI] = '{default: 0};
    longint unsigned m_out  [NI] = '{default: 0};
    int              m_cnt  [NI] = '{default: 0};
    bit              m_sat  [NI] = '{default: 1'b0};

    always @(posedge clk or negedge rst_n) begin
        longint unsigned s, lim;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_hold[i] = 0; m_sum[i] = 0; m_out[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
            end else if (clear) begin
                m_hold[i] = 0; m_sum[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
            end else if (m_hold[i]) begin
                if (acc_ready) m_hold[i] = 0;
            end else if (p_valid) begin
                lim = (64'd1 << aw_of(i)) - 1;
                s   = m_sum[i] + p_in;
                if (s > lim) begin
`ifdef MULT_ACC_SAT_EN
                    s = lim;
                    m_sat[i] = 1;
`else
                    s = s % (lim + 1);
`endif
                end
                if (m_cnt[i] == nt_of(i) - 1) begin
                    m_out[i] = s; m_sum[i] = 0; m_cnt[i] = 0; m_hold[i] = 1;
                end else begin
                    m_sum[i] = s; m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
    end

    task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                for (int i = 0; i < NI; i++) begin
                    check($sformatf("u%0d.acc_out", i), ao[i], m_out[i]);
                    check($sformatf("u%0d.acc_valid", i), 64'(av[i]), 64'(m_hold[i]));
                    check($sformatf("u%0d.p_ready", i), 64'(pr[i]), 64'(!m_hold[i] && !clear));
                    check($sformatf("u%0d.term_cnt", i), 64'(tc[i]), 64'(m_cnt[i]));
                    check($sformatf("u%0d.sat_flag", i), 64'(sf[i]), 64'(m_sat[i]));
                end
            end
        join_none

        step(); step();
        rst_n = 1'b1;
        step();
        check("reset_acc_out", ao[0], 0);
        check("reset_acc_valid", 64'(av[0]), 0);
        check("reset_term_cnt", 64'(tc[0]), 0);
        check("reset_p_ready", 64'(pr[0]), 1);

        // asynchronous reset in the middle of a sequence
        p_valid = 1'b1; p_in = 32'd5;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("async_rst_u%0d.acc_out", i), ao[i], 0);
            check($sformatf("async_rst_u%0d.acc_valid", i), 64'(av[i]), 0);
            check($sformatf("async_rst_u%0d.term_cnt", i), 64'(tc[i]), 0);
            check($sformatf("async_rst_u%0d.sat_flag", i), 64'(sf[i]), 0);
        end
        p_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_p_ready", 64'(pr[0]), 1);

        // 1,2,3,4 back to back into N_TERMS=4
        clear = 1'b1; step(); clear = 1'b0;
        acc_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            p_valid = 1'b1; p_in = 32'(k);
            step();
            if (k == 1) begin
                check("n1_acc_out", ao[4], 1);
                check("n1_acc_valid", 64'(av[4]), 1);
            end
        end
        p_valid = 1'b0;
        check("n4_acc_out", ao[0], 10);
        check("n4_acc_valid_pulse", 64'(av[0]), 1);
        check("n4_p_ready_bubble", 64'(pr[0]), 0);
        step();
        check("n4_acc_valid_drop", 64'(av[0]), 0);
        check("n4_p_ready_back", 64'(pr[0]), 1);

        // sixteen large products with the sink stalled
        clear = 1'b1; step(); clear = 1'b0;
        acc_ready = 1'b0; p_valid = 1'b1; p_in = 32'hFFFE_0001;
        repeat (16) step();
        p_valid = 1'b0;
        check("n16_acc_out", ao[1], 64'hF_FFE0_0010);
        for (int k = 0; k < 5; k++) begin
            step();
            check("n16_hold_valid", 64'(av[1]), 1);
            check("n16_hold_out", ao[1], 64'hF_FFE0_0010);
            check("n16_hold_p_ready", 64'(pr[1]), 0);
        end
        acc_ready = 1'b1;
        step();
        check("n16_release_valid", 64'(av[1]), 0);
        check("n16_release_p_ready", 64'(pr[1]), 1);

        // gapped input into N_TERMS=3
        clear = 1'b1; step(); clear = 1'b0;
        check("gap_term_cnt_start", 64'(tc[2]), 0);
        for (int k = 0; k < 3; k++) begin
            p_valid = 1'b1; p_in = 32'(100 * (k + 1));
            step();
            p_valid = 1'b0;
            check("gap_term_cnt", 64'(tc[2]), 64'((k + 1) % 3));
            if (k == 2) begin
                check("gap_acc_out", ao[2], 600);
                check("gap_acc_valid", 64'(av[2]), 1);
            end
            step(); step();
        end

        // clear mid-sequence, then clear while a result is held
        clear = 1'b1; step(); clear = 1'b0;
        acc_ready = 1'b0; p_valid = 1'b1;
        p_in = 32'd7; step();
        p_in = 32'd9; step();
        p_valid = 1'b0; clear = 1'b1; step(); clear = 1'b0;
        check("clr_term_cnt", 64'(tc[0]), 0);
        p_valid = 1'b1; p_in = 32'd1;
        repeat (4) step();
        p_valid = 1'b0;
        check("clr_acc_out", ao[0], 4);
        check("clr_acc_valid", 64'(av[0]), 1);
        step();
        clear = 1'b1; step(); clear = 1'b0;
        check("clr_hold_valid", 64'(av[0]), 0);
        check("clr_hold_out_kept", ao[0], 4);

        // overflow of a 33-bit accumulator
        acc_ready = 1'b1; p_valid = 1'b1; p_in = 32'hFFFF_FFFF;
        repeat (3) step();
        p_valid = 1'b0;
`ifdef MULT_ACC_SAT_EN
        check("ovf_acc_out", ao[3], 64'h1_FFFF_FFFF);
        check("ovf_sat_flag", 64'(sf[3]), 1);
`else
        check("ovf_acc_out", ao[3], 64'h0_FFFF_FFFD);
        check("ovf_sat_flag", 64'(sf[3]), 0);
`endif
        clear = 1'b1; step(); clear = 1'b0;
        check("ovf_sat_cleared", 64'(sf[3]), 0);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_acc_stage.md
Name: mult_acc_stage

Overview:
- Downstream consumer of the registered 32-bit product from the 16x16 approximate log-multiplier top.
- Accumulates a fixed-length sequence of unsigned products (dot-product / MAC reduction).
- Presents each completed sum on a valid/ready output interface.
- Decouples the free-running multiplier pipeline from a slower sink through an explicit handshake.

Parameters:
- P_WIDTH, 32: width of incoming product.
- ACC_WIDTH, 40: accumulator/output width; must be >= P_WIDTH.
- N_TERMS, 16: products summed per result; legal range 1..65535.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort: discards partial sum and any held result.
- p_in  in  P_WIDTH  unsigned product from multiplier.
- p_valid  in  1  p_in is valid this cycle.
- p_ready  out  1  stage accepts p_in this cycle.
- acc_out  out  ACC_WIDTH  completed sum.
- acc_valid  out  1  acc_out holds a completed result.
- acc_ready  in  1  sink accepts acc_out.
- term_cnt  out  16  products accepted in the current sequence.
- sat_flag  out  1  sticky saturation indicator (see Optional Feature).

Behaviour:
- Reset (rst_n low, async): state=ACCUM, accumulator=0, acc_out=0, acc_valid=0, term_cnt=0, sat_flag=0. p_ready=1 after reset release.
- States: ACCUM (collecting terms), HOLD (result presented).
- p_ready = (state==ACCUM) && !clear.
- A product is accepted when p_valid && p_ready.
- ACCUM, accept, term_cnt < N_TERMS-1:
  - acc <= acc + zero-extended p_in.
  - term_cnt increments by 1.
- ACCUM, accept, term_cnt == N_TERMS-1:
  - acc_out <= acc + p_in.
  - acc_valid <= 1; acc <= 0; term_cnt <= 0; go to HOLD.
  - Latency: acc_valid rises on the clock edge that accepts the last term (visible the following cycle).
- HOLD:
  - acc_out and acc_valid stable; p_ready=0.
  - On acc_ready=1: acc_valid <= 0, go to ACCUM. p_ready rises the next cycle, so at most one bubble cycle.
- acc_ready is ignored while acc_valid=0.
- p_valid without p_ready: p_in is dropped.
  - The upstream multiplier has no stall; the integrating top must gate p_valid with p_ready.
- clear (priority over every other input except rst_n):
  - Next edge: acc=0, term_cnt=0, acc_valid=0, state=ACCUM.
  - acc_out retains its last value; sat_flag is cleared.
  - A product presented in the clear cycle is not accepted.
- N_TERMS=1: every accepted product goes directly to HOLD, with acc_out = p_in.
- Arithmetic is unsigned. Overflow handling is defined only by the optional feature.
- Asserting rst_n mid-sequence or mid-HOLD discards all state immediately.

Optional Feature:
- Macro MULT_ACC_SAT_EN.
- Defined:
  - Each addition saturates at 2^ACC_WIDTH-1.
  - sat_flag is set on any saturating add and stays set until clear or reset.
- Undefined:
  - Addition wraps modulo 2^ACC_WIDTH.
  - sat_flag is tied to 0.

Decomposition:
- Package mult_acc_pkg:
  - State enum (ACCUM, HOLD).
  - Default width constants (P_WIDTH=32, ACC_WIDTH=40).
  - term_cnt width constant (16).
- Sub-module mult_acc_add: combinational ACC_WIDTH adder with the MULT_ACC_SAT_EN saturate/wrap switch and a saturation indicator output.
- FSM, counter and handshake stay in mult_acc_stage.

Test Plan:
- Reset mid-sequence: drive 5 products, pull rst_n low asynchronously between edges -> all outputs 0 immediately; p_ready=1 after release.
- N_TERMS=4, products 1,2,3,4 on consecutive cycles, acc_ready=1 -> acc_valid pulses one cycle with acc_out=10; p_ready low exactly one cycle.
- N_TERMS=16, all products 0xFFFE0001, acc_ready held low 5 cycles -> acc_out=0xFFFE00010, held stable with acc_valid=1 and p_ready=0 for all 5 cycles; releases on acc_ready.
- Gapped p_valid (1 of every 3 cycles), N_TERMS=3, products 100,200,300 -> acc_out=600; term_cnt steps 0,1,2,0.
- clear asserted after 2 of 4 terms (values 7,9), then 1,1,1,1 -> result 4, not 20; clear during HOLD drops acc_valid next edge.
- ACC_WIDTH=33, N_TERMS=3, products 0xFFFFFFFF x3:
  - Defined -> acc_out=0x1FFFFFFFF, sat_flag=1.
  - Undefined -> acc_out=0x0FFFFFFFD, sat_flag=0.
